// File: rtl/fft_pkg.sv
// Shared definitions for the FFT datapath: sample widths, block depth,
// the saturation bounds used by the downstream stage, and the butterfly
// FSM state encoding.
package fft_pkg;

    localparam int FFT_DIN_WIDTH = 13;
    localparam int FFT_WIDTH     = 14;
    localparam int FFT_DEPTH     = 16;
    localparam int FFT_SAT_MAX   = 4095;
    localparam int FFT_SAT_MIN   = -4096;

    typedef logic signed [FFT_DIN_WIDTH-1:0] sample_in_t;
    typedef logic signed [FFT_WIDTH-1:0]     sample_bf_t;

    typedef enum logic {
        WAIT_A = 1'b0,
        WAIT_B = 1'b1
    } bf_state_t;

endpackage

// File: rtl/bf_lane.sv
// One butterfly lane: holds the lane's A sample (R and Q) and produces
// registered A+B and A-B for both components when the B sample arrives.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   load_a_i             capture din_r_i/din_q_i as the A sample
//   compute_i            din_r_i/din_q_i are the B sample; update outputs
//   din_r_i, din_q_i     lane input sample (DIN_WIDTH signed)
//   add_r_o, sub_r_o     A_R + B_R, A_R - B_R (WIDTH signed)
//   add_q_o, sub_q_o     A_Q + B_Q, A_Q - B_Q (WIDTH signed)
module bf_lane
    import fft_pkg::*;
#(
    parameter int DIN_WIDTH = FFT_DIN_WIDTH,
    parameter int WIDTH     = FFT_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load_a_i,
    input  logic                        compute_i,
    input  logic signed [DIN_WIDTH-1:0] din_r_i,
    input  logic signed [DIN_WIDTH-1:0] din_q_i,
    output logic signed [WIDTH-1:0]     add_r_o,
    output logic signed [WIDTH-1:0]     sub_r_o,
    output logic signed [WIDTH-1:0]     add_q_o,
    output logic signed [WIDTH-1:0]     sub_q_o
);

    localparam int EXT = WIDTH - DIN_WIDTH;

    logic signed [DIN_WIDTH-1:0] a_r_q, a_r_d;
    logic signed [DIN_WIDTH-1:0] a_q_q, a_q_d;
    logic signed [WIDTH-1:0]     add_r_q, add_r_d;
    logic signed [WIDTH-1:0]     sub_r_q, sub_r_d;
    logic signed [WIDTH-1:0]     add_q_q, add_q_d;
    logic signed [WIDTH-1:0]     sub_q_q, sub_q_d;

    // Both operands sign-extended to the output width, so the sum and
    // difference of any two full-range inputs are exact.
    logic signed [WIDTH-1:0] a_r_ext, b_r_ext, a_q_ext, b_q_ext;

    assign a_r_ext = {{EXT{a_r_q[DIN_WIDTH-1]}}, a_r_q};
    assign b_r_ext = {{EXT{din_r_i[DIN_WIDTH-1]}}, din_r_i};
    assign a_q_ext = {{EXT{a_q_q[DIN_WIDTH-1]}}, a_q_q};
    assign b_q_ext = {{EXT{din_q_i[DIN_WIDTH-1]}}, din_q_i};

    always_comb begin
        // NOTE: every next-state value defaults to its current value first,
        // so no path through this block leaves a variable unassigned and no
        // latch is inferred.
        a_r_d   = a_r_q;
        a_q_d   = a_q_q;
        add_r_d = add_r_q;
        sub_r_d = sub_r_q;
        add_q_d = add_q_q;
        sub_q_d = sub_q_q;

        if (load_a_i) begin
            a_r_d = din_r_i;
            a_q_d = din_q_i;
        end

        if (compute_i) begin
            add_r_d = a_r_ext + b_r_ext;
            sub_r_d = a_r_ext - b_r_ext;
            add_q_d = a_q_ext + b_q_ext;
            sub_q_d = a_q_ext - b_q_ext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the A buffer is a handful of flops, not a RAM, so it is
        // reset along with the outputs; a held A must not survive reset.
        if (!rst_n) begin
            a_r_q   <= '0;
            a_q_q   <= '0;
            add_r_q <= '0;
            sub_r_q <= '0;
            add_q_q <= '0;
            sub_q_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // values from before this edge, independent of statement order.
            a_r_q   <= a_r_d;
            a_q_q   <= a_q_d;
            add_r_q <= add_r_d;
            sub_r_q <= sub_r_d;
            add_q_q <= add_q_d;
            sub_q_q <= sub_q_d;
        end
    end

    assign add_r_o = add_r_q;
    assign sub_r_o = sub_r_q;
    assign add_q_o = add_q_q;
    assign sub_q_o = sub_q_q;

endmodule

// File: rtl/radix2_butterfly_stage.sv
// Radix-2 butterfly stage. Pairs each A block of DEPTH complex samples with
// the following B block and presents registered A+B / A-B per lane, one
// bit wider than the input so no overflow is possible. Feeds the
// saturation stage lane-for-lane; dout_valid drives its enable.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   din_valid         din_R/din_Q carry a block this cycle
//   frame_start       with din_valid: this block is an A block
//   din_R, din_Q      DEPTH lanes of DIN_WIDTH signed samples
//   dout_valid        one-cycle pulse when dout_* were updated
//   dout_R_add/_sub   A_R +/- B_R per lane (WIDTH signed)
//   dout_Q_add/_sub   A_Q +/- B_Q per lane (WIDTH signed)
//   wait_b            an A block is held awaiting its B
//   pair_cnt          completed pairs since reset, wrapping
//
// WIDTH must equal DIN_WIDTH+1.
module radix2_butterfly_stage
    import fft_pkg::*;
#(
    parameter int DIN_WIDTH = FFT_DIN_WIDTH,
    parameter int WIDTH     = FFT_WIDTH,
    parameter int DEPTH     = FFT_DEPTH,
    parameter int CNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        din_valid,
    input  logic                        frame_start,
    input  logic signed [DIN_WIDTH-1:0] din_R      [DEPTH-1:0],
    input  logic signed [DIN_WIDTH-1:0] din_Q      [DEPTH-1:0],
    output logic                        dout_valid,
    output logic signed [WIDTH-1:0]     dout_R_add [DEPTH-1:0],
    output logic signed [WIDTH-1:0]     dout_R_sub [DEPTH-1:0],
    output logic signed [WIDTH-1:0]     dout_Q_add [DEPTH-1:0],
    output logic signed [WIDTH-1:0]     dout_Q_sub [DEPTH-1:0],
    output logic                        wait_b,
    output logic [CNT_WIDTH-1:0]        pair_cnt
);

    bf_state_t            state_q;
    logic                 wait_b_q;
    logic                 dout_valid_q;
    logic [CNT_WIDTH-1:0] pair_cnt_q;

    // frame_start re-anchors pairing: in WAIT_B it replaces the held A
    // instead of completing a pair.
    logic load_a;
    logic compute;

    assign load_a  = din_valid && ((state_q == WAIT_A) || frame_start);
    assign compute = din_valid && (state_q == WAIT_B) && !frame_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= WAIT_A;
            wait_b_q     <= 1'b0;
            dout_valid_q <= 1'b0;
            pair_cnt_q   <= '0;
        end else begin
            dout_valid_q <= 1'b0;
            if (din_valid) begin
                case (state_q)
                    WAIT_A: begin
                        state_q  <= WAIT_B;
                        wait_b_q <= 1'b1;
                    end
                    WAIT_B: begin
                        if (!frame_start) begin
                            state_q      <= WAIT_A;
                            wait_b_q     <= 1'b0;
                            dout_valid_q <= 1'b1;
                            pair_cnt_q   <= pair_cnt_q + CNT_WIDTH'(1);
                        end
                    end
                    default: begin
                        state_q  <= WAIT_A;
                        wait_b_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_lane
        bf_lane #(
            .DIN_WIDTH (DIN_WIDTH),
            .WIDTH     (WIDTH)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .load_a_i  (load_a),
            .compute_i (compute),
            .din_r_i   (din_R[i]),
            .din_q_i   (din_Q[i]),
            .add_r_o   (dout_R_add[i]),
            .sub_r_o   (dout_R_sub[i]),
            .add_q_o   (dout_Q_add[i]),
            .sub_q_o   (dout_Q_sub[i])
        );
    end

    assign dout_valid = dout_valid_q;
    assign wait_b     = wait_b_q;
    assign pair_cnt   = pair_cnt_q;

endmodule

// File: tb/tb_radix2_butterfly_stage.sv
// Scoreboard bench for radix2_butterfly_stage: stimulus pushes the expected
// result of each pair, a monitor pops and compares on every dout_valid.
module tb_radix2_butterfly_stage;

    localparam int DW = 13;
    localparam int W  = 14;
    localparam int D  = 16;
    localparam int CW = 16;

    typedef int lane_t [D];

    typedef struct {
        int r_add [D];
        int r_sub [D];
        int q_add [D];
        int q_sub [D];
        int cnt;
    } exp_t;

    logic                 clk;
    logic                 rst_n;
    logic                 din_valid;
    logic                 frame_start;
    logic signed [DW-1:0] din_R      [D-1:0];
    logic signed [DW-1:0] din_Q      [D-1:0];
    logic                 dout_valid;
    logic signed [W-1:0]  dout_R_add [D-1:0];
    logic signed [W-1:0]  dout_R_sub [D-1:0];
    logic signed [W-1:0]  dout_Q_add [D-1:0];
    logic signed [W-1:0]  dout_Q_sub [D-1:0];
    logic                 wait_b;
    logic [CW-1:0]        pair_cnt;

    int   checks    = 0;
    int   errors    = 0;
    int   exp_cnt   = 0;
    int   pulse_cnt = 0;
    exp_t sb [$];

    radix2_butterfly_stage #(
        .DIN_WIDTH (DW),
        .WIDTH     (W),
        .DEPTH     (D),
        .CNT_WIDTH (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din_valid   (din_valid),
        .frame_start (frame_start),
        .din_R       (din_R),
        .din_Q       (din_Q),
        .dout_valid  (dout_valid),
        .dout_R_add  (dout_R_add),
        .dout_R_sub  (dout_R_sub),
        .dout_Q_add  (dout_Q_add),
        .dout_Q_sub  (dout_Q_sub),
        .wait_b      (wait_b),
        .pair_cnt    (pair_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic drive(input bit v, input bit fs, input lane_t r, input lane_t q);
        @(posedge clk);
        #1;
        din_valid   = v;
        frame_start = fs;
        for (int i = 0; i < D; i++) begin
            din_R[i] = r[i][DW-1:0];
            din_Q[i] = q[i][DW-1:0];
        end
    endtask

    task automatic drive_uni(input bit fs, input int r, input int q);
        lane_t ra, qa;
        for (int i = 0; i < D; i++) begin
            ra[i] = r;
            qa[i] = q;
        end
        drive(1'b1, fs, ra, qa);
    endtask

    task automatic idle();
        lane_t z;
        for (int i = 0; i < D; i++) z[i] = 0;
        drive(1'b0, 1'b0, z, z);
    endtask

    task automatic push_uni(input int radd, input int rsub, input int qadd, input int qsub);
        exp_t e;
        for (int i = 0; i < D; i++) begin
            e.r_add[i] = radd;
            e.r_sub[i] = rsub;
            e.q_add[i] = qadd;
            e.q_sub[i] = qsub;
        end
        exp_cnt++;
        e.cnt = exp_cnt;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_dout_valid", int'(dout_valid), 0);
        check("rst_wait_b", int'(wait_b), 0);
        check("rst_pair_cnt", int'(pair_cnt), 0);
        check("rst_R_add0", int'(dout_R_add[0]), 0);
        check("rst_Q_sub15", int'(dout_Q_sub[D-1]), 0);
        sb.delete();
        exp_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compares every output pulse against the scoreboard head.
    initial begin
        bit prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
            end else begin
                if (dout_valid) begin
                    pulse_cnt++;
                    check("no_back_to_back", int'(prev_valid), 0);
                    if (sb.size() == 0) begin
                        check("unexpected_dout_valid", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        for (int i = 0; i < D; i++) begin
                            check($sformatf("R_add[%0d]", i), int'(dout_R_add[i]), e.r_add[i]);
                            check($sformatf("R_sub[%0d]", i), int'(dout_R_sub[i]), e.r_sub[i]);
                            check($sformatf("Q_add[%0d]", i), int'(dout_Q_add[i]), e.q_add[i]);
                            check($sformatf("Q_sub[%0d]", i), int'(dout_Q_sub[i]), e.q_sub[i]);
                        end
                        check("pair_cnt", int'(pair_cnt), e.cnt);
                    end
                end
                prev_valid = dout_valid;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        lane_t ra, qa, rb, qb;
        exp_t  e;
        int    pulses_before;

        rst_n       = 1'b0;
        din_valid   = 1'b0;
        frame_start = 1'b0;
        for (int i = 0; i < D; i++) begin
            din_R[i] = '0;
            din_Q[i] = '0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("init_dout_valid", int'(dout_valid), 0);
        check("init_wait_b", int'(wait_b), 0);
        check("init_pair_cnt", int'(pair_cnt), 0);
        check("init_R_add3", int'(dout_R_add[3]), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic pair
        drive_uni(1'b0, 100, -50);
        push_uni(130, 70, -30, -70);
        drive_uni(1'b0, 30, 20);
        check("basic_wait_b_after_A", int'(wait_b), 1);
        idle();
        check("basic_wait_b_after_B", int'(wait_b), 0);

        // Extremes
        drive_uni(1'b0, 4095, 0);
        push_uni(-1, 8191, 0, 0);
        drive_uni(1'b0, -4096, 0);
        drive_uni(1'b0, -4096, 4095);
        push_uni(-8192, 0, 8190, 0);
        drive_uni(1'b0, -4096, 4095);

        // Per-lane distinct: A_R=i, B_R=-2i, A_Q=-i, B_Q=i
        for (int i = 0; i < D; i++) begin
            ra[i] = i;
            qa[i] = -i;
            rb[i] = -2 * i;
            qb[i] = i;
            e.r_add[i] = -i;
            e.r_sub[i] = 3 * i;
            e.q_add[i] = 0;
            e.q_sub[i] = -2 * i;
        end
        drive(1'b1, 1'b0, ra, qa);
        exp_cnt++;
        e.cnt = exp_cnt;
        sb.push_back(e);
        drive(1'b1, 1'b0, rb, qb);
        idle();

        // Gap: A, five idle cycles, then B
        drive_uni(1'b0, 1000, -1000);
        for (int k = 0; k < 5; k++) begin
            idle();
            check("gap_wait_b", int'(wait_b), 1);
            check("gap_hold_R_add5", int'(dout_R_add[5]), -5);
            check("gap_hold_R_sub5", int'(dout_R_sub[5]), 15);
        end
        push_uni(976, 1024, -976, -1024);
        drive_uni(1'b0, -24, 24);
        idle();

        // Resync: A1=10, frame_start A2=20, B=5
        drive_uni(1'b0, 10, 0);
        drive_uni(1'b1, 20, -3);
        check("resync_wait_b", int'(wait_b), 1);
        push_uni(25, 15, -6, 0);
        drive_uni(1'b0, 5, -3);
        check("resync_wait_b_still", int'(wait_b), 1);
        check("resync_pair_cnt_before", int'(pair_cnt), 5);
        idle();
        check("resync_pair_cnt_after", int'(pair_cnt), 6);
        idle();

        // Reset mid-operation: A=7 discarded
        drive_uni(1'b0, 7, 7);
        idle();
        do_reset();
        drive_uni(1'b0, 3, 3);
        idle();
        check("midrst_wait_b", int'(wait_b), 1);
        check("midrst_pair_cnt", int'(pair_cnt), 0);
        check("midrst_R_add0", int'(dout_R_add[0]), 0);
        push_uni(4, 2, 4, 2);
        drive_uni(1'b0, 1, 1);
        idle();
        idle();

        // Streaming: 200 back-to-back blocks
        do_reset();
        pulses_before = pulse_cnt;
        for (int k = 0; k < 200; k++) begin
            for (int i = 0; i < D; i++) begin
                rb[i] = ((k * 397 + i * 1013 + 11) % 8192) - 4096;
                qb[i] = ((k * 731 + i * 577 + 4000) % 8192) - 4096;
            end
            if (k % 2 == 1) begin
                for (int i = 0; i < D; i++) begin
                    e.r_add[i] = ra[i] + rb[i];
                    e.r_sub[i] = ra[i] - rb[i];
                    e.q_add[i] = qa[i] + qb[i];
                    e.q_sub[i] = qa[i] - qb[i];
                end
                exp_cnt++;
                e.cnt = exp_cnt;
                sb.push_back(e);
            end else begin
                ra = rb;
                qa = qb;
            end
            drive(1'b1, 1'b0, rb, qb);
        end
        repeat (4) idle();
        check("stream_pulses", pulse_cnt - pulses_before, 100);
        check("stream_pair_cnt", int'(pair_cnt), 100);
        check("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
